// File: rtl/sram_1rw_sched.sv
// sram_1rw_sched: owns the single RW0 port of a 1RW SRAM macro. It first
// sweeps the array to INIT_VALUE, then shares the port between one write
// requester and one read requester using round-robin arbitration.
module sram_1rw_sched #(
    parameter int              DEPTH      = 256,
    parameter int              AW         = 8,
    parameter int              DW         = 13,
    parameter logic [DW-1:0]   INIT_VALUE = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_req,
    output logic          init_done,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          r_valid,
    output logic          r_ready,
    input  logic [AW-1:0] r_addr,
    output logic          resp_valid,
    output logic [DW-1:0] resp_data,
    output logic          sram_en,
    output logic          sram_wmode,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    localparam logic [0:0]    ST_INIT    = 1'b0;
    localparam logic [0:0]    ST_RUN     = 1'b1;
    localparam logic          PRIO_WRITE = 1'b0;
    localparam logic          PRIO_READ  = 1'b1;
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

    logic [0:0]    state_reg;
    logic [AW-1:0] cnt_reg;
    logic          prio_reg;
    logic          resp_valid_reg;

    logic          in_init;
    logic          in_run;
    logic          w_grant;
    logic          r_grant;

    // Reset masks everything so the macro is never touched while reset is held.
    assign in_init = (state_reg == ST_INIT) && !reset;
    assign in_run  = (state_reg == ST_RUN) && !reset;

    assign init_done = in_run;
    assign w_ready   = in_run && !clear_req && (!r_valid || prio_reg == PRIO_WRITE);
    assign r_ready   = in_run && !clear_req && (!w_valid || prio_reg == PRIO_READ);
    // The two readies are never both high while both valids are high,
    // so at most one of these grants fires per cycle.
    assign w_grant   = w_valid && w_ready;
    assign r_grant   = r_valid && r_ready;

    assign resp_valid = resp_valid_reg && !reset;
    assign resp_data  = sram_rdata;

    // Port mux: sweep writes during INIT, otherwise the granted requester.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (in_init) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = cnt_reg;
            sram_wdata = INIT_VALUE;
        end else if (w_grant) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_addr;
            sram_wdata = w_data;
        end else if (r_grant) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b0;
            sram_addr  = r_addr;
        end
    end

    // Sweep sequencing, clear handling, round-robin priority and response flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_INIT;
            cnt_reg        <= '0;
            prio_reg       <= PRIO_WRITE;
            resp_valid_reg <= 1'b0;
        end else begin
            // A read granted just before a clear still gets its response,
            // since the macro returns the data before the sweep starts.
            resp_valid_reg <= r_grant;
            if (state_reg == ST_INIT) begin
                // clear_req is ignored here; the running sweep just finishes.
                if (cnt_reg == LAST_ADDR) begin
                    state_reg <= ST_RUN;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else if (clear_req) begin
                state_reg <= ST_INIT;
                cnt_reg   <= '0;
            end
            if (w_grant) begin
                prio_reg <= PRIO_READ;
            end else if (r_grant) begin
                prio_reg <= PRIO_WRITE;
            end
        end
    end

endmodule

// File: tb/tb_sram_1rw_sched.sv
// tb_sram_1rw_sched: drives directed scenarios and then random traffic into
// sram_1rw_sched with a behavioural 1RW macro attached, and compares every
// cycle against a transaction-level model of the scheduler's rules.
module tb_sram_1rw_sched;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int DW    = 13;
    localparam logic [DW-1:0] INIT_VAL = '0;

    logic          clk;
    logic          reset;
    logic          clear_req;
    logic          init_done;
    logic          w_valid;
    logic          w_ready;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          r_valid;
    logic          r_ready;
    logic [AW-1:0] r_addr;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          sram_en;
    logic          sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    int checks_cnt = 0;
    int errors_cnt = 0;

    sram_1rw_sched #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT_VALUE(INIT_VAL)
    ) dut (
        .clock(clk), .reset(reset), .clear_req(clear_req), .init_done(init_done),
        .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macro: write-or-read per cycle, read data one cycle later.
    logic [DW-1:0] macro_mem [DEPTH];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wmode) macro_mem[sram_addr] <= sram_wdata;
            else            sram_rdata <= macro_mem[sram_addr];
        end
    end

    // Reference model: sweep position, round-robin turn, expected contents,
    // and the response owed in the next cycle.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_init;
    int            ref_sweep;
    bit            ref_write_turn;
    bit            ref_pend;
    logic [DW-1:0] ref_pend_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance model.
    task automatic step(input logic rst, input logic clr,
                        input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic rv, input logic [AW-1:0] ra);
        bit run, exp_wr, exp_rr, wg, rg, exp_en, exp_resp;
        reset = rst; clear_req = clr;
        w_valid = wv; w_addr = wa; w_data = wd;
        r_valid = rv; r_addr = ra;
        @(negedge clk);
        run      = !rst && !ref_init;
        exp_wr   = run && !clr && (!rv || ref_write_turn);
        exp_rr   = run && !clr && (!wv || !ref_write_turn);
        wg       = wv && exp_wr;
        rg       = rv && exp_rr;
        exp_en   = !rst && (ref_init || wg || rg);
        exp_resp = !rst && ref_pend;
        check_val("init_done", 32'(init_done), 32'(run));
        check_val("w_ready", 32'(w_ready), 32'(exp_wr));
        check_val("r_ready", 32'(r_ready), 32'(exp_rr));
        check_val("sram_en", 32'(sram_en), 32'(exp_en));
        check_val("resp_valid", 32'(resp_valid), 32'(exp_resp));
        if (exp_resp) begin
            check_val("resp_data", 32'(resp_data), 32'(ref_pend_data));
            $display("RESP data=0x%04h exp=0x%04h", resp_data, ref_pend_data);
        end
        if (exp_en) begin
            check_val("sram_wmode", 32'(sram_wmode), 32'(!rg));
            if (!rst && ref_init) begin
                check_val("sweep_addr", 32'(sram_addr), 32'(ref_sweep));
                check_val("sweep_data", 32'(sram_wdata), 32'(INIT_VAL));
            end else if (wg) begin
                check_val("wr_addr", 32'(sram_addr), 32'(wa));
                check_val("wr_data", 32'(sram_wdata), 32'(wd));
                $display("WRITE addr=0x%02h data=0x%04h", wa, wd);
            end else begin
                check_val("rd_addr", 32'(sram_addr), 32'(ra));
                $display("READ  addr=0x%02h", ra);
            end
        end
        if (rst) begin
            ref_init = 1; ref_sweep = 0; ref_write_turn = 1; ref_pend = 0;
        end else begin
            ref_pend = 0;
            if (ref_init) begin
                ref_mem[ref_sweep] = INIT_VAL;
                if (ref_sweep == DEPTH - 1) begin
                    ref_init = 0; ref_sweep = 0;
                end else begin
                    ref_sweep++;
                end
            end else if (clr) begin
                ref_init = 1; ref_sweep = 0;
            end else if (wg) begin
                ref_mem[wa] = wd; ref_write_turn = 0;
            end else if (rg) begin
                ref_pend = 1; ref_pend_data = ref_mem[ra]; ref_write_turn = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, '0);
    endtask

    // Counts idle cycles until init_done rises, bounded.
    task automatic count_sweep(output int n);
        n = 0;
        while (!init_done && n < DEPTH + 20) begin
            step(0, 0, 0, '0, '0, 0, '0);
            n++;
        end
    endtask

    initial begin
        int n;
        bit rst_r, clr_r, wv_r, rv_r;
        ref_init = 1; ref_sweep = 0; ref_write_turn = 1; ref_pend = 0; ref_pend_data = '0;
        reset = 1; clear_req = 0; w_valid = 0; r_valid = 0;
        w_addr = '0; w_data = '0; r_addr = '0;
        @(posedge clk); #1;

        // T1: reset then full sweep of DEPTH cycles before init_done.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 8'h3, 13'h5, 1, 8'h4);
        count_sweep(n);
        check_val("t1_sweep_len", 32'(n), 32'(DEPTH));

        // T2: write then read-after-write.
        step(0, 0, 1, 8'h12, 13'h1ABC, 0, '0);
        step(0, 0, 0, '0, '0, 1, 8'h12);
        idle(1);

        // T3: both requesters held high; grants alternate.
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'(8'h20 + i), 13'(13'h100 + i), 1, 8'(8'h20 + i));
        idle(1);

        // T4: read, then clear in the following cycle; old data still returned.
        step(0, 0, 1, 8'h05, 13'h0777, 0, '0);
        step(0, 0, 0, '0, '0, 1, 8'h05);
        step(0, 1, 0, '0, '0, 0, '0);
        count_sweep(n);
        check_val("t4_sweep_len", 32'(n), 32'(DEPTH));
        step(0, 0, 0, '0, '0, 1, 8'h05);
        idle(1);

        // T5: clear during the sweep at position 100 is ignored.
        step(0, 1, 0, '0, '0, 0, '0);
        idle(100);
        step(0, 1, 0, '0, '0, 0, '0);
        count_sweep(n);
        check_val("t5_sweep_len", 32'(n), 32'(DEPTH - 101));

        // T6: reset right after a read grant drops the response.
        step(0, 0, 1, 8'h33, 13'h0ABC, 0, '0);
        step(0, 0, 0, '0, '0, 1, 8'h33);
        step(1, 0, 0, '0, '0, 0, '0);
        count_sweep(n);
        check_val("t6_sweep_len", 32'(n), 32'(DEPTH));

        // Random traffic over a small address window so reads hit recent writes.
        for (int i = 0; i < 1500; i++) begin
            rst_r = ($urandom_range(0, 499) == 0);
            clr_r = ($urandom_range(0, 199) == 0);
            wv_r  = ($urandom_range(0, 99) < 60);
            rv_r  = ($urandom_range(0, 99) < 60);
            step(rst_r, clr_r, wv_r, 8'($urandom_range(0, 15)), 13'($urandom),
                 rv_r, 8'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
